// File: rtl/sensor_event_arbiter.sv
// sensor_event_arbiter
// Collects spike events from N_SENSORS 4-phase req/ack sensor lines and
// arbitrates them round-robin. Each grant is encoded as a sensor address and
// written to a show-ahead FIFO, which feeds the controller through
// event_addr/event_valid/event_ready.
//
// Handshakes:
//   sensor side : 4-phase. ack rises on the grant edge, holds while req=1,
//                 and clears on the first edge that samples req=0.
//   event side  : valid/ready. A pop happens on an edge where
//                 event_valid && event_ready. event_valid never depends
//                 combinationally on event_ready or sensor_req.
//
// Optional feature macro: SENSOR_REFRACTORY_EN
//   When defined, each sensor gets a lockout counter. The counter is loaded
//   with REFRACT_CYCLES on the grant edge and counts down while the sensor's
//   ack is low.
module sensor_event_arbiter #(
  parameter int N_SENSORS      = 16,
  parameter int ADDR_W         = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_SENSORS-1:0]          sensor_req,
  output logic [N_SENSORS-1:0]          sensor_ack,
  output logic [ADDR_W-1:0]             event_addr,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Reject parameter combinations the address encoding cannot represent.
  if (ADDR_W != $clog2(N_SENSORS) || FIFO_DEPTH < 2 || REFRACT_CYCLES < 0) begin : g_param_check
    $error("sensor_event_arbiter: inconsistent parameters");
  end

  logic [N_SENSORS-1:0] eligible;
  logic [ADDR_W-1:0]    rr_ptr;
  logic                 grant_found;
  logic [ADDR_W-1:0]    grant_idx;
  logic                 grant_valid;
  logic                 pop;
  logic                 can_push;

  logic [ADDR_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     rd_ptr_nxt;

  assign event_valid = (fifo_count != '0);
  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop         = event_valid && event_ready;
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign can_push    = !fifo_full || pop;
  assign grant_valid = grant_found && can_push;
  assign rd_ptr_nxt  = rd_ptr + PTR_W'(1);

`ifdef SENSOR_REFRACTORY_EN
  localparam int RC_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  logic [RC_W-1:0]      refr_cnt [N_SENSORS];
  logic [N_SENSORS-1:0] refr_busy;

  // A sensor is locked out while its counter is non-zero.
  always_comb begin
    refr_busy = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      refr_busy[i] = (refr_cnt[i] != '0);
    end
  end

  assign eligible = sensor_req & ~sensor_ack & ~refr_busy;

  // Load on grant; count down only once the 4-phase cycle has dropped ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SENSORS; i++) refr_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (grant_valid && grant_idx == ADDR_W'(i)) begin
          refr_cnt[i] <= RC_W'(REFRACT_CYCLES);
        end else if (!sensor_ack[i] && refr_busy[i]) begin
          refr_cnt[i] <= refr_cnt[i] - RC_W'(1);
        end
      end
    end
  end
`else
  assign eligible = sensor_req & ~sensor_ack;
`endif

  // Round-robin search: start at rr_ptr, ascend, and wrap; the first eligible sensor wins.
  always_comb begin
    int                sum;
    logic [ADDR_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    idx         = '0;
    for (int off = 0; off < N_SENSORS; off++) begin
      sum = int'(rr_ptr) + off;
      if (sum >= N_SENSORS) sum = sum - N_SENSORS;
      idx = ADDR_W'(sum);
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // FIFO storage; the pointers and occupancy guard every read of stale slots.
  always_ff @(posedge clock) begin
    if (grant_valid) mem[wr_ptr] <= grant_idx;
  end

  // Acks, round-robin pointer, FIFO pointers/occupancy, and the registered head address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sensor_ack <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      event_addr <= '0;
    end else begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (sensor_ack[i]) begin
          sensor_ack[i] <= sensor_req[i];
        end else if (grant_valid && grant_idx == ADDR_W'(i)) begin
          sensor_ack[i] <= 1'b1;
        end
      end

      if (grant_valid) begin
        rr_ptr <= (grant_idx == ADDR_W'(N_SENSORS - 1)) ? '0 : grant_idx + ADDR_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (pop) rd_ptr <= rd_ptr_nxt;

      case ({grant_valid, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      // The head register shows the next entry. It holds its last value when the FIFO drains.
      if (pop) begin
        if (fifo_count > CNT_W'(1)) begin
          event_addr <= mem[rd_ptr_nxt];
        end else if (grant_valid) begin
          event_addr <= grant_idx;
        end
      end else if (grant_valid && fifo_count == '0) begin
        event_addr <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_sensor_event_arbiter.sv
// Directed bench for sensor_event_arbiter. Every expected event address is
// queued when its stimulus is issued. A monitor pops the queue on each
// accepted event and compares. Occupancy, full and ack are checked directly.
module tb_sensor_event_arbiter;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int D  = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  sensor_req = '0;
  logic [N-1:0]  sensor_ack;
  logic [AW-1:0] event_addr;
  logic          event_valid;
  logic          event_ready = 1'b0;
  logic          fifo_full;
  logic [3:0]    fifo_count;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_q[$];

  sensor_event_arbiter #(
    .N_SENSORS(N), .ADDR_W(AW), .FIFO_DEPTH(D), .REFRACT_CYCLES(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .sensor_req(sensor_req), .sensor_ack(sensor_ack),
    .event_addr(event_addr), .event_valid(event_valid),
    .event_ready(event_ready), .fifo_full(fifo_full),
    .fifo_count(fifo_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n     = 1'b0;
    sensor_req  = '0;
    event_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  // monitor / scoreboard: sample mid low phase, ahead of the edge that pops
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset_n && event_valid === 1'b1 && event_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got addr %0d, expected no event", event_addr);
        end else begin
          chk("pop_addr", 32'(event_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    // 1: reset with req[1] held, then the first grant and the ack release
    reset_n = 1'b0; sensor_req = 16'h0002; event_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ack",   32'(sensor_ack), 32'h0);
    chk("rst_valid", 32'(event_valid), 32'h0);
    chk("rst_addr",  32'(event_addr), 32'h0);
    chk("rst_full",  32'(fifo_full), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    reset_n = 1'b1;
    exp_q.push_back(4'd1);
    @(negedge clock);
    chk("t1_valid", 32'(event_valid), 32'h1);
    chk("t1_addr",  32'(event_addr), 32'h1);
    chk("t1_ack",   32'(sensor_ack), 32'h0002);
    chk("t1_count", 32'(fifo_count), 32'h1);
    @(negedge clock);
    chk("t1_ack_hold",   32'(sensor_ack), 32'h0002);
    chk("t1_count_hold", 32'(fifo_count), 32'h1);
    sensor_req = '0;
    @(negedge clock);
    chk("t1_ack_clear", 32'(sensor_ack), 32'h0);
    event_ready = 1'b1;
    @(negedge clock);
    event_ready = 1'b0;
    chk("t1_empty_valid", 32'(event_valid), 32'h0);
    chk("t1_empty_count", 32'(fifo_count), 32'h0);
    chk("t1_addr_held",   32'(event_addr), 32'h1);

    // 2: round robin between sensors 0 and 15
    do_reset();
    sensor_req = 16'h8001;
    exp_q.push_back(4'd0); exp_q.push_back(4'd15);
    exp_q.push_back(4'd0); exp_q.push_back(4'd15);
    @(negedge clock);
    chk("rr_ack1", 32'(sensor_ack), 32'h0001);
    chk("rr_cnt1", 32'(fifo_count), 32'd1);
    @(negedge clock);
    chk("rr_ack2", 32'(sensor_ack), 32'h8001);
    chk("rr_cnt2", 32'(fifo_count), 32'd2);
    sensor_req = '0;
    @(negedge clock);
    chk("rr_ack_rel",  32'(sensor_ack), 32'h0);
    chk("rr_cnt_hold", 32'(fifo_count), 32'd2);
    sensor_req = 16'h8001;
    @(negedge clock);
    chk("rr_ack3", 32'(sensor_ack), 32'h0001);
    chk("rr_cnt3", 32'(fifo_count), 32'd3);
    @(negedge clock);
    chk("rr_ack4", 32'(sensor_ack), 32'h8001);
    chk("rr_cnt4", 32'(fifo_count), 32'd4);
    sensor_req = '0; event_ready = 1'b1;
    repeat (4) @(negedge clock);
    event_ready = 1'b0;
    chk("rr_drained", 32'(fifo_count), 32'd0);

    // 3: fill to full, block a 9th sensor, then push and pop on the same edge
    do_reset();
    sensor_req = 16'h02FF;
    for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
    exp_q.push_back(4'd9);
    repeat (8) @(negedge clock);
    chk("fill_full",  32'(fifo_full), 32'h1);
    chk("fill_count", 32'(fifo_count), 32'd8);
    chk("fill_ack",   32'(sensor_ack), 32'h00FF);
    repeat (2) @(negedge clock);
    chk("blocked_ack",   32'(sensor_ack), 32'h00FF);
    chk("blocked_count", 32'(fifo_count), 32'd8);
    event_ready = 1'b1;
    @(negedge clock);
    event_ready = 1'b0;
    chk("slot_ack",   32'(sensor_ack), 32'h02FF);
    chk("slot_count", 32'(fifo_count), 32'd8);
    chk("slot_full",  32'(fifo_full), 32'h1);
    sensor_req = '0; event_ready = 1'b1;
    repeat (8) @(negedge clock);
    event_ready = 1'b0;
    chk("fill_drained_count", 32'(fifo_count), 32'd0);
    chk("fill_drained_valid", 32'(event_valid), 32'h0);

    // 4: pop order 3, 7, 12
    do_reset();
    sensor_req = 16'h1088;
    exp_q.push_back(4'd3); exp_q.push_back(4'd7); exp_q.push_back(4'd12);
    repeat (3) @(negedge clock);
    chk("po_count", 32'(fifo_count), 32'd3);
    chk("po_head1", 32'(event_addr), 32'd3);
    sensor_req = '0; event_ready = 1'b1;
    @(negedge clock);
    chk("po_head2", 32'(event_addr), 32'd7);
    @(negedge clock);
    chk("po_head3", 32'(event_addr), 32'd12);
    @(negedge clock);
    event_ready = 1'b0;
    chk("po_valid",     32'(event_valid), 32'h0);
    chk("po_count_end", 32'(fifo_count), 32'd0);
    chk("po_addr_held", 32'(event_addr), 32'd12);

    // 5: push into an empty FIFO with ready already high -- no bypass
    do_reset();
    event_ready = 1'b1; sensor_req = 16'h0020;
    exp_q.push_back(4'd5);
    @(negedge clock);
    chk("ep_valid", 32'(event_valid), 32'h1);
    chk("ep_addr",  32'(event_addr), 32'd5);
    chk("ep_count", 32'(fifo_count), 32'd1);
    @(negedge clock);
    chk("ep_valid_gone", 32'(event_valid), 32'h0);
    chk("ep_count_gone", 32'(fifo_count), 32'd0);
    @(negedge clock);
    chk("ep_valid_stays", 32'(event_valid), 32'h0);
    sensor_req = '0; event_ready = 1'b0;

    // 6: immediate re-request by sensor 2
    do_reset();
    event_ready = 1'b1; sensor_req = 16'h0004;
    exp_q.push_back(4'd2);
    @(negedge clock);
    chk("rf_ack1", 32'(sensor_ack), 32'h0004);
    sensor_req = '0;
    @(negedge clock);
    chk("rf_ack_clr", 32'(sensor_ack), 32'h0);
    sensor_req = 16'h0004;
    exp_q.push_back(4'd2);
`ifdef SENSOR_REFRACTORY_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rf_locked", 32'(sensor_ack), 32'h0);
    end
`endif
    @(negedge clock);
    chk("rf_regrant", 32'(sensor_ack), 32'h0004);
    sensor_req = '0;
    repeat (2) @(negedge clock);
    event_ready = 1'b0;
    chk("rf_count_end", 32'(fifo_count), 32'd0);
    chk("final_queue",  32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_event_arbiter.md
Name: sensor_event_arbiter

Overview:
Upstream stage of the SNN core. Collects spike events from N_SENSORS sensor lines using a per-sensor 4-phase req/ack handshake, arbitrates them round-robin and encodes each into a sensor address. Buffers the addresses in a show-ahead FIFO and presents them to the controller as event_addr/event_valid, replacing the hard-wired sensor event address and event-received signals. The controller pops one event per processed spike with event_ready.

Parameters:
N_SENSORS, 16, number of sensor request lines
ADDR_W, 4, event address width; must equal $clog2(N_SENSORS)
FIFO_DEPTH, 8, event buffer entries; power of two, >= 2
REFRACT_CYCLES, 4, per-sensor lockout cycles after an ack (used only with the optional feature)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
sensor_req  input  N_SENSORS  per-sensor event request, level, synchronous to clock
sensor_ack  output  N_SENSORS  per-sensor acknowledge, registered
event_addr  output  ADDR_W  address of the FIFO head event
event_valid  output  1  FIFO not empty (event_addr is valid)
event_ready  input  1  controller pops head when event_valid && event_ready
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release): sensor_ack=0, FIFO empty, event_valid=0, event_addr=0, fifo_full=0, fifo_count=0, RR pointer=0, refractory counters=0.
- Eligibility of sensor i: sensor_req[i]=1 and sensor_ack[i]=0 (and not refractory when the feature is enabled).
- Grant: at most one per cycle. Search starts at the RR pointer, ascending, wraps at N_SENSORS-1 -> 0. First eligible sensor wins.
- Grant is allowed only if can_push = !fifo_full || pop, where pop = event_valid && event_ready.
- On a grant to sensor g at edge k:
  - g is written to the FIFO tail.
  - sensor_ack[g] goes to 1 after edge k.
  - RR pointer becomes (g+1) mod N_SENSORS.
  - No grant: pointer holds.
- Ack release: sensor_ack[i] stays 1 while sensor_req[i]=1. It clears on the first edge that samples sensor_req[i]=0. Sensor i is not eligible again until req=0 and ack=0 (full 4-phase cycle).
- Latency: req sampled at edge k with an empty FIFO gives event_valid=1 and event_addr=g after edge k. There is no combinational req->event_valid path.
- FIFO is show-ahead: event_addr always shows the head entry. When empty, event_addr holds its last value, event_valid=0, and event_ready is ignored.
- Simultaneous push and pop: both happen and occupancy is unchanged. This applies when full (push accepted because of the pop) and when count=1.
- Push when empty plus event_ready: no bypass; the pop is ignored because event_valid=0 that cycle.
- Full with no pop: no grant, no ack. Requests wait and no event is lost.
- Pointers are ADDR-width of the FIFO and wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH by construction.
- Reset mid-handshake: acks drop. A sensor still holding req is re-granted after reset as a new event (by design).

Optional Feature:
SENSOR_REFRACTORY_EN
- Defined: each sensor has a counter loaded with REFRACT_CYCLES on its grant edge. It decrements each cycle while sensor_ack[i]=0 and is >0. Sensor i is ineligible while its counter is non-zero. This suppresses chattering sensors.
- Undefined: no counters; eligibility is req && !ack only, and REFRACT_CYCLES is unused.

Test Plan:
1. Reset with sensor_req=16'h0002 held -> outputs 0 during reset. After release: edge 1 gives event_addr=1, event_valid=1, sensor_ack[1]=1. Ack stays 1 until req drops, then clears the next edge.
2. Round-robin: sensor_req=16'h8001 held and acks released each time, no pops -> grant order 0, 15, 0, 15, pointer wraps. fifo_count increments by 1 per grant.
3. Fill: 8 distinct sensors request, event_ready=0 -> fifo_full=1, fifo_count=8. A 9th request stays unacked. Raise event_ready for 1 cycle -> 9th sensor granted the same edge, count stays 8.
4. Pop order: push addresses 3,7,12, then event_ready=1 -> event_addr sequence 3,7,12, then event_valid=0 and fifo_count=0.
5. Empty push plus ready: event_ready=1 constant, single req on sensor 5 -> event_valid high exactly 1 cycle with event_addr=5.
6. SENSOR_REFRACTORY_EN, REFRACT_CYCLES=4: sensor 2 completes its handshake and re-requests immediately -> no grant until 4 cycles after ack fell. Without the macro -> re-granted on the first edge req is sampled with ack=0.
